// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, issues in-order word fetches and buffers returned instructions for decode.
// Optional FETCH_MISALIGN_CHECK_EN: a misaligned redirect target latches a sticky fault and halts fetch.
module fetch_sequencer #(
  parameter int XLEN = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = {XLEN{1'b0}},
  parameter int BUF_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_address,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_address,
  input  logic            imem_resp_valid,
  input  logic [XLEN-1:0] imem_resp_data,
  output logic            instr_valid,
  input  logic            instr_ready,
  output logic [XLEN-1:0] instr_data,
  output logic [XLEN-1:0] instr_pc,
  output logic            misalign_fault
);
  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = 16;
  localparam logic [AW:0] DEPTH_C = (AW+1)'(BUF_DEPTH);

`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;
`else
  typedef enum logic {BOOT, RUN} state_t;
`endif

  state_t               state;
  logic [XLEN-1:0]      fetch_pc;
  logic [XLEN-1:0]      slot_pc   [BUF_DEPTH];
  logic [XLEN-1:0]      slot_data [BUF_DEPTH];
  logic [BUF_DEPTH-1:0] slot_filled;
  logic [AW-1:0]        head, tail, fill_ptr;
  logic [AW:0]          count;
  logic [CW-1:0]        outstanding, outstanding_next, drop_count;
  logic                 running, in_fault, slot_free, req_fire, pop, resp_keep;

  assign running          = (state == RUN);
  assign instr_valid      = running && slot_filled[head] && !redirect_valid;
  assign pop              = instr_valid && instr_ready;
  // A head pop frees a slot in the same cycle, which keeps 1-cycle memory at full rate with two slots.
  assign slot_free        = (count != DEPTH_C) || pop;
  assign imem_req_valid   = running && slot_free && !redirect_valid;
  assign imem_req_address = fetch_pc;
  assign req_fire         = imem_req_valid && imem_req_ready;
  assign instr_data       = slot_data[head];
  assign instr_pc         = slot_pc[head];
  assign resp_keep        = imem_resp_valid && (drop_count == '0) && !in_fault;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault_flag;
  logic bad_target;
  assign in_fault       = (state == FAULT);
  assign bad_target     = (redirect_address[1:0] != 2'b00);
  assign misalign_fault = fault_flag;
`else
  logic unused_low_bits;
  assign unused_low_bits = ^redirect_address[1:0];
  assign in_fault        = 1'b0;
  assign misalign_fault  = 1'b0;
`endif

  // Requests issued but not yet answered, including those already marked for dropping.
  always_comb begin
    outstanding_next = outstanding;
    if (req_fire && !imem_resp_valid)
      outstanding_next = outstanding + CW'(1);
    else if (!req_fire && imem_resp_valid)
      outstanding_next = outstanding - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= BOOT;
      fetch_pc    <= RESET_VECTOR;
      slot_filled <= '0;
      head        <= '0;
      tail        <= '0;
      fill_ptr    <= '0;
      count       <= '0;
      outstanding <= '0;
      drop_count  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        slot_pc[i]   <= '0;
        slot_data[i] <= '0;
      end
`ifdef FETCH_MISALIGN_CHECK_EN
      fault_flag  <= 1'b0;
`endif
    end else begin
      outstanding <= outstanding_next;
      if (state == BOOT)
        state <= RUN;
      if (redirect_valid && !in_fault) begin
        slot_filled <= '0;
        head        <= '0;
        tail        <= '0;
        fill_ptr    <= '0;
        count       <= '0;
        drop_count  <= outstanding_next;
        fetch_pc    <= {redirect_address[XLEN-1:2], 2'b00};
`ifdef FETCH_MISALIGN_CHECK_EN
        if (bad_target) begin
          state      <= FAULT;
          fault_flag <= 1'b1;
        end
`endif
      end else begin
        if (req_fire) begin
          slot_pc[tail] <= fetch_pc;
          tail          <= tail + AW'(1);
          fetch_pc      <= fetch_pc + XLEN'(4);
        end
        if (imem_resp_valid && (drop_count != '0))
          drop_count <= drop_count - CW'(1);
        if (resp_keep) begin
          slot_data[fill_ptr]   <= imem_resp_data;
          slot_filled[fill_ptr] <= 1'b1;
          fill_ptr              <= fill_ptr + AW'(1);
        end
        if (pop) begin
          slot_filled[head] <= 1'b0;
          head              <= head + AW'(1);
        end
        if (req_fire && !pop)
          count <= count + (AW+1)'(1);
        else if (!req_fire && pop)
          count <= count - (AW+1)'(1);
      end
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed stimulus pushes expected requests/instructions; a negedge monitor pops and compares.
// Define FETCH_MISALIGN_CHECK_EN on both bench and design to exercise the fault path.
`timescale 1ns/1ps
module tb_fetch_sequencer;
  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_address;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_address;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        misalign_fault;

  always #5 clk = ~clk;

  fetch_sequencer #(.XLEN(32), .RESET_VECTOR(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_address(redirect_address),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_address(imem_req_address),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr_data(instr_data), .instr_pc(instr_pc),
    .misalign_fault(misalign_fault)
  );

  typedef struct { logic [31:0] pc; logic [31:0] data; } instr_t;
  typedef struct { int due; logic [31:0] addr; } mresp_t;

  instr_t      exp_instr[$];
  logic [31:0] exp_req[$];
  mresp_t      mem_q[$];
  int          req_cyc[$];
  int          instr_cyc[$];
  int          vectors = 0;
  int          errors = 0;
  int          cyc = 0;
  int          lat = 1;
  instr_t      mon_e;
  logic [31:0] mon_a;
  mresp_t      mon_m;

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic push_pair(input logic [31:0] a);
    exp_req.push_back(a);
    exp_instr.push_back('{a, mem_data(a)});
  endtask

  task automatic wait_req_empty(input int lim);
    int n = 0;
    while (exp_req.size() != 0 && n < lim) begin
      @(posedge clk); #2;
      n++;
    end
    chk("req_drain", exp_req.size(), 0);
  endtask

  task automatic wait_instr_empty(input int lim);
    int n = 0;
    while (exp_instr.size() != 0 && n < lim) begin
      @(posedge clk); #2;
      n++;
    end
    chk("instr_drain", exp_instr.size(), 0);
  endtask

  // Monitor plus memory model: latency `lat`, in-order, never back-pressured.
  always @(negedge clk) begin
    if (rst) begin
      mem_q.delete();
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        req_cyc.push_back(cyc);
        if (exp_req.size() == 0) begin
          vectors++; errors++;
          $display("FAIL req_unexpected: got %h, expected none", imem_req_address);
        end else begin
          mon_a = exp_req.pop_front();
          chk("req_addr", imem_req_address, mon_a);
        end
      end
      if (instr_valid && instr_ready) begin
        instr_cyc.push_back(cyc);
        if (exp_instr.size() == 0) begin
          vectors++; errors++;
          $display("FAIL instr_unexpected: got pc %h, expected none", instr_pc);
        end else begin
          mon_e = exp_instr.pop_front();
          chk("instr_pc", instr_pc, mon_e.pc);
          chk("instr_data", instr_data, mon_e.data);
        end
      end
      imem_resp_valid = 1'b0;
      if (mem_q.size() != 0 && mem_q[0].due <= cyc) begin
        mon_m = mem_q.pop_front();
        imem_resp_valid = 1'b1;
        imem_resp_data  = mem_data(mon_m.addr);
      end
      if (imem_req_valid && imem_req_ready)
        mem_q.push_back('{cyc + lat, imem_req_address});
    end
    cyc++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_address = '0;
    imem_req_ready = 1'b0; instr_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_address, 32'h0);
    chk("rst_instr_valid", instr_valid, 0);
    chk("rst_instr_data", instr_data, 32'h0);
    chk("rst_instr_pc", instr_pc, 32'h0);
    chk("rst_misalign", misalign_fault, 0);

    // Streaming from reset with 1-cycle memory.
    rst = 1'b0;
    #1 chk("boot_no_req", imem_req_valid, 0);
    for (int i = 0; i < 8; i++) push_pair(32'(i * 4));
    req_cyc.delete(); instr_cyc.delete();
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    @(posedge clk); #2;
    chk("first_req_valid", imem_req_valid, 1);
    chk("first_req_addr", imem_req_address, 32'h0);
    wait_req_empty(40);
    imem_req_ready = 1'b0;
    wait_instr_empty(40);
    chk("p1_req_count", req_cyc.size(), 8);
    chk("p1_req_span", (req_cyc.size() >= 8) ? req_cyc[7] - req_cyc[0] : -1, 7);
    chk("p1_instr_span", (instr_cyc.size() >= 8) ? instr_cyc[7] - instr_cyc[0] : -1, 7);

    // Decode stalled for 5 cycles: only two requests fit.
    req_cyc.delete();
    instr_ready = 1'b0;
    push_pair(32'h20); push_pair(32'h24);
    imem_req_ready = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    for (int k = 0; k < 3; k++) begin
      chk("stall_req_valid", imem_req_valid, 0);
      chk("stall_instr_valid", instr_valid, 1);
      chk("stall_instr_pc", instr_pc, 32'h20);
      chk("stall_instr_data", instr_data, 32'hDEAD_0020);
      @(posedge clk); #3;
    end
    imem_req_ready = 1'b0; instr_ready = 1'b1;
    chk("stall_req_count", req_cyc.size(), 2);
    wait_instr_empty(20);

    // Redirect with two stale requests in flight (3-cycle memory).
    lat = 3;
    exp_req.push_back(32'h28); exp_req.push_back(32'h2C);
    imem_req_ready = 1'b1;
    wait_req_empty(10);
    redirect_valid = 1'b1; redirect_address = 32'h100;
    for (int i = 0; i < 4; i++) push_pair(32'h100 + 32'(i * 4));
    @(posedge clk); #2;
    redirect_valid = 1'b0;
    #1;
    chk("redir_req_valid", imem_req_valid, 1);
    chk("redir_req_addr", imem_req_address, 32'h100);
    wait_req_empty(60);
    imem_req_ready = 1'b0;
    wait_instr_empty(60);

    // Redirect coinciding with a response and a ready decode stage.
    lat = 1;
    exp_req.push_back(32'h110); exp_req.push_back(32'h114);
    imem_req_ready = 1'b1;
    repeat (2) begin @(posedge clk); #2; end
    redirect_valid = 1'b1; redirect_address = 32'h200;
    #1;
    chk("redir_kill_instr", instr_valid, 0);
    chk("redir_kill_req", imem_req_valid, 0);
    for (int i = 0; i < 4; i++) push_pair(32'h200 + 32'(i * 4));
    instr_cyc.delete();
    @(posedge clk); #2;
    redirect_valid = 1'b0;
    wait_req_empty(30);
    imem_req_ready = 1'b0;
    wait_instr_empty(30);
    chk("p4_instr_count", instr_cyc.size(), 4);
    chk("p4_instr_span", (instr_cyc.size() >= 4) ? instr_cyc[3] - instr_cyc[0] : -1, 3);

    // PC wraps past the top of the address space.
    redirect_valid = 1'b1; redirect_address = 32'hFFFF_FFF8;
    push_pair(32'hFFFF_FFF8); push_pair(32'hFFFF_FFFC);
    push_pair(32'h0000_0000); push_pair(32'h0000_0004);
    imem_req_ready = 1'b1;
    @(posedge clk); #2;
    redirect_valid = 1'b0;
    wait_req_empty(30);
    imem_req_ready = 1'b0;
    wait_instr_empty(30);

    // Misaligned redirect target.
    redirect_valid = 1'b1; redirect_address = 32'h102;
    imem_req_ready = 1'b1;
`ifdef FETCH_MISALIGN_CHECK_EN
    @(posedge clk); #2;
    redirect_valid = 1'b0;
    #1;
    chk("fault_set", misalign_fault, 1);
    chk("fault_req_valid", imem_req_valid, 0);
    redirect_valid = 1'b1; redirect_address = 32'h300;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #3;
      redirect_valid = 1'b0;
      chk("fault_sticky", misalign_fault, 1);
      chk("fault_no_req", imem_req_valid, 0);
      chk("fault_no_instr", instr_valid, 0);
    end
    imem_req_ready = 1'b0;
`else
    push_pair(32'h100); push_pair(32'h104);
    @(posedge clk); #2;
    redirect_valid = 1'b0;
    #1;
    chk("nofault_flag", misalign_fault, 0);
    chk("nofault_req_addr", imem_req_address, 32'h100);
    wait_req_empty(30);
    imem_req_ready = 1'b0;
    wait_instr_empty(30);
`endif

    // Reset mid-run returns everything to reset values, then fetch restarts.
    rst = 1'b1;
    @(posedge clk); #2;
    chk("rst2_req_valid", imem_req_valid, 0);
    chk("rst2_req_addr", imem_req_address, 32'h0);
    chk("rst2_instr_valid", instr_valid, 0);
    chk("rst2_instr_pc", instr_pc, 32'h0);
    chk("rst2_instr_data", instr_data, 32'h0);
    chk("rst2_misalign", misalign_fault, 0);
    rst = 1'b0;
    push_pair(32'h0); push_pair(32'h4);
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    wait_req_empty(30);
    imem_req_ready = 1'b0;
    wait_instr_empty(30);

    repeat (3) @(posedge clk);
    #2;
    chk("final_req_q", exp_req.size(), 0);
    chk("final_instr_q", exp_instr.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
